reset_sequencer: RTL and testbench

- Parametrised successor to the single-output power-on reset generator: drives NUM_CH active-low domain resets and releases them in a fixed staggered order (ch0 first) after a power-on hold.
- Adds runtime re-reset from a debounced DE-10 pushbutton and a soft request pulse from game logic, plus cause reporting.
- Sits at the top level between the board clock/upstream reset and every functional domain: VGA, game FSM, input, audio.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_seq_key_debounce.sv | 47 ++++
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staggered domain reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_KEY  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  // Counter width able to hold the largest of the three hold/gap lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_key_debounce.sv
// Pushbutton synchroniser and debouncer; pulses press_evt once per accepted press.
module key_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_evt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q, stable_q, evt_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      db_cnt_q <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      evt_q   <= 1'b0;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_q <= sync2_q;
          db_cnt_q <= '0;
          // Only the press (falling) edge is reported.
          evt_q    <= ~sync2_q;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / re-arm reset generator releasing NUM_CH active-low domain resets in order.
//   state   | meaning
//   HOLD    | all domains held in reset for hold_len cycles
//   RELEASE | domains released one at a time, STAGE_GAP cycles apart
//   RUN     | all domains released, waiting for a re-reset request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int POR_CYCLES      = 1000000,
  parameter int REARM_CYCLES    = 50000,
  parameter int STAGE_GAP       = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] rst_n,
  output logic              done,
  output logic [1:0]        last_cause
);

  localparam int CNT_W = cnt_width(POR_CYCLES, REARM_CYCLES, STAGE_GAP);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] POR_LEN   = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] REARM_LEN = CNT_W'(REARM_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hold_len_q, hold_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic              key_evt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .press_evt(key_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_len_q <= POR_LEN;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      hold_len_q <= hold_len_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_n_q    <= rst_n_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_len_d = hold_len_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_n_d    = rst_n_q;
    done_d     = done_q;
    cause_d    = cause_q;
    idx_nxt    = idx_q + IDX_W'(1);

    if (key_evt || soft_req) begin
      // Key wins over soft when both arrive together.
      state_d    = HOLD;
      hold_len_d = REARM_LEN;
      cnt_d      = '0;
      idx_d      = '0;
      rst_n_d    = '0;
      done_d     = 1'b0;
      cause_d    = key_evt ? CAUSE_KEY : CAUSE_SOFT;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == hold_len_q - CNT_W'(1)) begin
            cnt_d      = '0;
            idx_d      = '0;
            rst_n_d[0] = 1'b1;
            if (NUM_CH == 1) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_nxt;
            for (int k = 1; k < NUM_CH; k++) begin
              if (k == int'(idx_nxt)) rst_n_d[k] = 1'b1;
            end
            if (idx_nxt == IDX_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign rst_n      = rst_n_q;
  assign done       = done_q;
  assign last_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: timing model of the staggered release plus directed literal checks.
module tb_reset_sequencer;

  localparam int NUM_CH = 3;
  localparam int POR    = 10;
  localparam int REARM  = 5;
  localparam int GAP    = 3;
  localparam int DB     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              key_n;
  logic              soft_req;
  logic [NUM_CH-1:0] rst_n;
  logic              done;
  logic [1:0]        last_cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_CH(NUM_CH), .POR_CYCLES(POR), .REARM_CYCLES(REARM),
    .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .soft_req(soft_req),
    .rst_n(rst_n), .done(done), .last_cause(last_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: edges elapsed since the current hold began; channel k is out of
  // reset once hold + k*GAP edges have passed.
  int   m_t, m_hold, m_cause, m_streak;
  bit   m_valid = 0;
  bit   m_evt, m_new_evt, m_p1, m_p2, m_stable;

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_hold = POR; m_cause = 0;
      m_p1 = 1; m_p2 = 1; m_stable = 1; m_streak = 0; m_evt = 0;
      m_valid = 1;
    end else begin
      if (m_evt || soft_req) begin
        m_t = 0; m_hold = REARM; m_cause = m_evt ? 1 : 2;
      end else if (m_t < 1000000) begin
        m_t++;
      end
      // A press is accepted after DB consecutive edges of a changed synced level.
      m_new_evt = 0;
      if (m_p2 != m_stable) begin
        m_streak++;
        if (m_streak == DB) begin
          m_stable  = m_p2;
          m_streak  = 0;
          m_new_evt = !m_p2;
        end
      end else begin
        m_streak = 0;
      end
      m_p2  = m_p1;
      m_p1  = key_n;
      m_evt = m_new_evt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [NUM_CH-1:0] e_rst;
      for (int k = 0; k < NUM_CH; k++) e_rst[k] = (m_t >= m_hold + k * GAP);
      chk("model_rst_n", 32'(rst_n), 32'(e_rst));
      chk("model_done", 32'(done), 32'(m_t >= m_hold + (NUM_CH - 1) * GAP));
      chk("model_cause", 32'(last_cause), 32'(m_cause));
    end
  end

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_soft();
    soft_req = 1'b1;
    neg(1);
    soft_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b1; soft_req = 1'b0;
    neg(3);
    chk("reset_rst_n", 32'(rst_n), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_cause", 32'(last_cause), 32'h0);
    reset = 1'b0;

    // 1: power-on release
    neg(9);  chk("por_e9", 32'(rst_n), 32'b000);
    neg(1);  chk("por_e10", 32'(rst_n), 32'b001);
    neg(2);  chk("por_e12", 32'(rst_n), 32'b001);
    neg(1);  chk("por_e13", 32'(rst_n), 32'b011);
    neg(2);  chk("por_e15", 32'(rst_n), 32'b011);
    chk("por_e15_done", 32'(done), 32'h0);
    neg(1);  chk("por_e16", 32'(rst_n), 32'b111);
    chk("por_e16_done", 32'(done), 32'h1);
    neg(4);

    // 2: soft re-reset from RUN
    pulse_soft();
    chk("soft_rst_n", 32'(rst_n), 32'b000);
    chk("soft_cause", 32'(last_cause), 32'h2);
    neg(4);  chk("soft_hold4", 32'(rst_n), 32'b000);
    neg(1);  chk("soft_rel0", 32'(rst_n), 32'b001);
    neg(3);  chk("soft_rel1", 32'(rst_n), 32'b011);
    neg(3);  chk("soft_done", 32'(done), 32'h1);
    neg(5);

    // 3: bounced key press, then release
    for (int i = 0; i < 2; i++) begin
      key_n = 1'b0; neg(2);
      key_n = 1'b1; neg(2);
    end
    chk("bounce_no_reassert", 32'(rst_n), 32'b111);
    key_n = 1'b0;
    neg(6);  chk("key_e6", 32'(rst_n), 32'b111);
    neg(1);  chk("key_e7", 32'(rst_n), 32'b000);
    chk("key_cause", 32'(last_cause), 32'h1);
    neg(25);
    key_n = 1'b1;
    neg(15);
    chk("key_release_done", 32'(done), 32'h1);
    chk("key_release_cause", 32'(last_cause), 32'h1);

    // 4: request while only channel 0 is out of reset
    pulse_soft();
    neg(5);  chk("mid_only_ch0", 32'(rst_n), 32'b001);
    pulse_soft();
    chk("mid_reassert", 32'(rst_n), 32'b000);
    neg(4);  chk("mid_hold4", 32'(rst_n), 32'b000);
    neg(1);  chk("mid_rel0", 32'(rst_n), 32'b001);
    neg(10);

    // 5: key event and soft request on the same cycle
    key_n = 1'b0;
    neg(6);
    pulse_soft();
    chk("both_rst_n", 32'(rst_n), 32'b000);
    chk("both_cause", 32'(last_cause), 32'h1);
    neg(4);  chk("both_hold4", 32'(rst_n), 32'b000);
    neg(1);  chk("both_rel0", 32'(rst_n), 32'b001);
    key_n = 1'b1;
    neg(15);

    // 6: reset asserted during RELEASE
    pulse_soft();
    neg(6);
    chk("mid_reset_pre_cause", 32'(last_cause), 32'h2);
    reset = 1'b1;
    neg(1);
    chk("mid_reset_rst_n", 32'(rst_n), 32'b000);
    chk("mid_reset_cause", 32'(last_cause), 32'h0);
    reset = 1'b0;
    neg(9);  chk("mid_reset_e9", 32'(rst_n), 32'b000);
    neg(1);  chk("mid_reset_e10", 32'(rst_n), 32'b001);
    neg(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
